// File: rtl/log_compress_stream.sv
// Streaming fixed-point log2 of mel filterbank energies, tagged with the filter index in the frame.
// Define LOG_COMPRESS_LN_EN to add a fourth stage that rescales the result to natural log.
module log_compress_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int LOG_WIDTH   = 8,
  parameter int FRAC_BITS   = 3,
  parameter int NUM_FILTERS = 26,
  parameter int LUT_BITS    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [DATA_WIDTH-1:0]   in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic signed [LOG_WIDTH-1:0]    out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [$clog2(NUM_FILTERS)-1:0] out_index,
  input  logic                           out_ready,
  output logic                           frame_err,
  input  logic                           err_clr
);

  localparam int IDX_W       = $clog2(NUM_FILTERS);
  localparam int P_W         = $clog2(DATA_WIDTH);
  localparam int RES_W       = P_W + FRAC_BITS + 1;
  localparam int MAG_W       = LOG_WIDTH - 1;
  localparam int LOG_MAX_MAG = (2 ** MAG_W) - 1;
  localparam logic signed [LOG_WIDTH-1:0] LOG_MIN = {1'b1, {MAG_W{1'b0}}};

  // LUT[m] = round(log2(1 + m/2^LUT_BITS) * 2^FRAC_BITS), built at elaboration by repeated squaring.
  function automatic logic [FRAC_BITS:0] lut_val(input int m);
    logic [63:0] v;
    logic [31:0] frac;
    v    = 64'((2 ** LUT_BITS) + m) << (30 - LUT_BITS);
    frac = '0;
    for (int i = 0; i < 24; i++) begin
      v    = (v * v) >> 30;
      frac = {frac[30:0], 1'b0};
      if (v >= (64'd2 << 30)) begin
        frac[0] = 1'b1;
        v       = v >> 1;
      end
    end
    frac = (frac + (32'd1 << (23 - FRAC_BITS))) >> (24 - FRAC_BITS);
    return frac[FRAC_BITS:0];
  endfunction

  logic [FRAC_BITS:0] lut [2**LUT_BITS];
  for (genvar g = 0; g < 2**LUT_BITS; g++) begin : g_lut
    localparam logic [FRAC_BITS:0] LV = lut_val(g);
    assign lut[g] = LV;
  end

  // Handshake: a transfer happens on valid && ready at either port. The whole pipeline
  // advances together whenever the output register is empty or being drained.
  logic adv, accept;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  logic [IDX_W-1:0] frame_cnt;
  logic             cnt_end, err_event;
  assign cnt_end   = (frame_cnt == IDX_W'(NUM_FILTERS - 1));
  assign err_event = accept && (in_last != cnt_end);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      if (accept) frame_cnt <= (in_last || cnt_end) ? '0 : frame_cnt + IDX_W'(1);
      if (err_event)    frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end

  logic                  s1_valid, s1_nonpos, s1_last;
  logic [DATA_WIDTH-2:0] s1_mag;
  logic [IDX_W-1:0]      s1_idx;
  logic                  s2_valid, s2_nonpos, s2_last;
  logic [P_W-1:0]        s2_p;
  logic [LUT_BITS-1:0]   s2_m;
  logic [IDX_W-1:0]      s2_idx;

  logic [P_W-1:0]      lod_p;
  logic [LUT_BITS-1:0] mant;
  logic [RES_W-1:0]    res;
  logic [MAG_W-1:0]    sat_mag;

  always_comb begin
    lod_p = '0;
    for (int i = 0; i < DATA_WIDTH - 1; i++) begin
      if (s1_mag[i]) lod_p = P_W'(i);
    end
  end

  // Appending LUT_BITS zeros makes short values zero-pad the mantissa after the shift.
  assign mant = LUT_BITS'({s1_mag, {LUT_BITS{1'b0}}} >> lod_p);

  assign res     = {1'b0, s2_p, {FRAC_BITS{1'b0}}} + RES_W'(lut[s2_m]);
  assign sat_mag = (32'(res) > 32'(LOG_MAX_MAG)) ? '1 : MAG_W'(res);

`ifdef LOG_COMPRESS_LN_EN
  localparam int LN2_Q16 = 45426;
  localparam int PROD_W  = LOG_WIDTH + 17;

  logic             s3_valid, s3_nonpos, s3_last;
  logic [MAG_W-1:0] s3_mag;
  logic [IDX_W-1:0] s3_idx;
  logic [MAG_W-1:0] ln_mag;

  assign ln_mag = MAG_W'((PROD_W'(s3_mag) * PROD_W'(LN2_Q16) + PROD_W'(32768)) >> 16);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_nonpos <= 1'b0;
      s1_last   <= 1'b0;
      s1_mag    <= '0;
      s1_idx    <= '0;
      s2_valid  <= 1'b0;
      s2_nonpos <= 1'b0;
      s2_last   <= 1'b0;
      s2_p      <= '0;
      s2_m      <= '0;
      s2_idx    <= '0;
`ifdef LOG_COMPRESS_LN_EN
      s3_valid  <= 1'b0;
      s3_nonpos <= 1'b0;
      s3_last   <= 1'b0;
      s3_mag    <= '0;
      s3_idx    <= '0;
`endif
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_index <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_nonpos <= in_data[DATA_WIDTH-1] || (in_data[DATA_WIDTH-2:0] == '0);
      s1_mag    <= in_data[DATA_WIDTH-2:0];
      s1_idx    <= frame_cnt;
      s1_last   <= cnt_end;

      s2_valid  <= s1_valid;
      s2_nonpos <= s1_nonpos;
      s2_p      <= lod_p;
      s2_m      <= mant;
      s2_idx    <= s1_idx;
      s2_last   <= s1_last;

`ifdef LOG_COMPRESS_LN_EN
      s3_valid  <= s2_valid;
      s3_nonpos <= s2_nonpos;
      s3_mag    <= sat_mag;
      s3_idx    <= s2_idx;
      s3_last   <= s2_last;

      out_valid <= s3_valid;
      out_data  <= s3_nonpos ? LOG_MIN : {1'b0, ln_mag};
      out_index <= s3_idx;
      out_last  <= s3_last;
`else
      out_valid <= s2_valid;
      out_data  <= s2_nonpos ? LOG_MIN : {1'b0, sat_mag};
      out_index <= s2_idx;
      out_last  <= s2_last;
`endif
    end
  end

endmodule

// File: tb/tb_log_compress_stream.sv
// Directed bench for log_compress_stream: hand-computed log2 (or ln with LOG_COMPRESS_LN_EN) vectors,
// frame tagging, framing errors, backpressure and reset flush.
module tb_log_compress_stream;

  localparam int DW = 16;
  localparam int LW = 8;
  localparam int NF = 26;
  localparam int IW = $clog2(NF);
`ifdef LOG_COMPRESS_LN_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 in_ready;
  logic signed [LW-1:0] out_data;
  logic                 out_valid;
  logic                 out_last;
  logic [IW-1:0]        out_index;
  logic                 out_ready = 1'b1;
  logic                 frame_err;
  logic                 err_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [LW-1:0] exp_q[$];

  log_compress_stream dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_index(out_index), .out_ready(out_ready), .frame_err(frame_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; err_clr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Presents one sample and returns 1ns after the edge that accepted it.
  task automatic send(input logic signed [DW-1:0] d, input logic last, input logic clr);
    int w;
    in_data = d; in_last = last; err_clr = clr; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %0b want 0", out_last); end
    n_vec++; if (out_index !== '0) begin n_err++; $display("FAIL reset_out_index: got %0d want 0", out_index); end
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_single();
    logic signed [DW-1:0] din [7];
    logic signed [LW-1:0] ed [7];
    din = '{16'sd1, 16'sd2, 16'sd3, 16'sd0, -16'sd5, 16'sd32767, 16'sd16384};
`ifdef LOG_COMPRESS_LN_EN
    ed  = '{8'sd0, 8'sd6, 8'sd9, -8'sd128, -8'sd128, 8'sd83, 8'sd78};
`else
    ed  = '{8'sd0, 8'sd8, 8'sd13, -8'sd128, -8'sd128, 8'sd120, 8'sd112};
`endif
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      send(din[i], 1'b0, 1'b0);
      repeat (LAT - 2) tick();
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL single_early[%0d]: out_valid=%0b want 0 one cycle before latency", i, out_valid);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== ed[i]) begin
        n_err++; $display("FAIL single_data[%0d]: valid=%0b data=%0d want valid=1 data=%0d", i, out_valid, out_data, ed[i]);
      end
      n_vec++;
      if (out_index !== IW'(i) || out_last !== 1'b0) begin
        n_err++; $display("FAIL single_tag[%0d]: index=%0d last=%0b want index=%0d last=0", i, out_index, out_last, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] din [4];
    logic signed [LW-1:0] ed [4];
    int w;
    din = '{16'sd4, 16'sd8, 16'sd16, 16'sd32};
`ifdef LOG_COMPRESS_LN_EN
    ed  = '{8'sd11, 8'sd17, 8'sd22, 8'sd28};
`else
    ed  = '{8'sd16, 8'sd24, 8'sd32, 8'sd40};
`endif
    apply_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) send(din[i], 1'b0, 1'b0);
      end
      begin
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        for (int k = 0; k < 4; k++) begin
          n_vec++;
          if (out_valid !== 1'b1 || out_data !== ed[k] || out_index !== IW'(k)) begin
            n_err++;
            $display("FAIL b2b[%0d]: valid=%0b data=%0d index=%0d want valid=1 data=%0d index=%0d",
                     k, out_valid, out_data, out_index, ed[k], k);
          end
          @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_frame();
    logic signed [LW-1:0] fexp [NF];
    logic signed [LW-1:0] e_d, h_d;
    logic [IW-1:0] h_i;
    logic h_l, held, mon_done;
    int got;
`ifdef LOG_COMPRESS_LN_EN
    fexp = '{8'sd0, 8'sd6, 8'sd9, 8'sd11, 8'sd13, 8'sd15, 8'sd15, 8'sd17, 8'sd17, 8'sd19, 8'sd19, 8'sd20, 8'sd21,
             8'sd21, 8'sd21, 8'sd22, 8'sd23, 8'sd23, 8'sd24, 8'sd24, 8'sd24, 8'sd25, 8'sd25, 8'sd26, 8'sd26, 8'sd26};
`else
    fexp = '{8'sd0, 8'sd8, 8'sd13, 8'sd16, 8'sd19, 8'sd21, 8'sd22, 8'sd24, 8'sd25, 8'sd27, 8'sd28, 8'sd29, 8'sd30,
             8'sd30, 8'sd31, 8'sd32, 8'sd33, 8'sd33, 8'sd34, 8'sd35, 8'sd35, 8'sd36, 8'sd36, 8'sd37, 8'sd37, 8'sd38};
`endif
    apply_reset();
    exp_q.delete();
    for (int i = 0; i < NF; i++) exp_q.push_back(fexp[i]);
    got = 0; held = 1'b0; mon_done = 1'b0;
    h_d = '0; h_i = '0; h_l = 1'b0;
    fork
      begin
        for (int i = 0; i < NF; i++) send(DW'(i + 1), (i == NF - 1), 1'b0);
      end
      begin
        while (!mon_done) begin
          @(posedge clk);
          #1;
          out_ready = !out_ready;
        end
        out_ready = 1'b1;
      end
      begin
        for (int c = 0; c < 400 && got < NF; c++) begin
          @(negedge clk);
          if (held) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== h_d || out_index !== h_i || out_last !== h_l) begin
              n_err++;
              $display("FAIL stall_hold: valid=%0b data=%0d index=%0d last=%0b want 1/%0d/%0d/%0b",
                       out_valid, out_data, out_index, out_last, h_d, h_i, h_l);
            end
          end
          held = 1'b0;
          if (out_valid === 1'b1) begin
            if (out_ready) begin
              if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL frame_extra: unexpected output data=%0d index=%0d", out_data, out_index);
              end else begin
                e_d = exp_q.pop_front();
                n_vec++;
                if (out_data !== e_d || out_index !== IW'(got) || out_last !== (got == NF - 1)) begin
                  n_err++;
                  $display("FAIL frame_out[%0d]: data=%0d index=%0d last=%0b want %0d/%0d/%0b",
                           got, out_data, out_index, out_last, e_d, got, (got == NF - 1));
                end
              end
              got++;
            end else begin
              held = 1'b1; h_d = out_data; h_i = out_index; h_l = out_last;
            end
          end
        end
        mon_done = 1'b1;
      end
    join
    n_vec++;
    if (got != NF) begin n_err++; $display("FAIL frame_count: got %0d outputs want %0d", got, NF); end
    n_vec++;
    if (frame_err !== 1'b0) begin n_err++; $display("FAIL frame_err_clean: got %0b want 0", frame_err); end
  endtask

  task automatic test_frame_err();
    logic signed [LW-1:0] e70;
`ifdef LOG_COMPRESS_LN_EN
    e70 = 8'sd34;
`else
    e70 = 8'sd49;
`endif
    apply_reset();
    for (int i = 0; i < 9; i++) send(DW'(50 + i), 1'b0, 1'b0);
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL err_before_last: got %0b want 0", frame_err); end
    send(16'sd60, 1'b1, 1'b0);
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL err_early_last: got %0b want 1", frame_err); end
    send(16'sd70, 1'b0, 1'b0);
    repeat (LAT - 1) tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_data !== e70) begin
      n_err++; $display("FAIL err_wrap_index: valid=%0b index=%0d data=%0d want 1/0/%0d", out_valid, out_index, out_data, e70);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %0b want 0", frame_err); end
    for (int i = 1; i < NF - 1; i++) send(DW'(100 + i), 1'b0, 1'b0);
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL err_mid_frame: got %0b want 0", frame_err); end
    send(16'sd200, 1'b0, 1'b0);
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL err_missing_last: got %0b want 1", frame_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    send(16'sd300, 1'b0, 1'b0);
    n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL err_clear_again: got %0b want 0", frame_err); end
    send(16'sd301, 1'b1, 1'b1);
    n_vec++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL err_set_beats_clr: got %0b want 1", frame_err); end
  endtask

  task automatic test_reset_flight();
    logic signed [LW-1:0] e100;
`ifdef LOG_COMPRESS_LN_EN
    e100 = 8'sd37;
`else
    e100 = 8'sd53;
`endif
    apply_reset();
    send(16'sd10, 1'b0, 1'b0);
    send(16'sd20, 1'b0, 1'b0);
    send(16'sd30, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_index !== '0) begin
      n_err++; $display("FAIL flight_async_reset: valid=%0b data=%0d index=%0d want 0/0/0", out_valid, out_data, out_index);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 1) tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flight_discard: out_valid=%0b want 0", out_valid); end
    send(16'sd100, 1'b0, 1'b0);
    repeat (LAT - 1) tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_data !== e100) begin
      n_err++; $display("FAIL flight_first_after: valid=%0b index=%0d data=%0d want 1/0/%0d", out_valid, out_index, out_data, e100);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame();
    test_frame_err();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
